// File: rtl/fifo_wr_gen.sv
// fifo_wr_gen -- write-side traffic generator for the FIFO bench.
// Drives wen/wdata into a FIFO write port in the write clock domain and
// honours backpressure from full. It generates incrementing, LFSR or
// bursty-incrementing data, either for a programmed word count or
// continuously until stopped.
//
// Ports:
//   wclk, rstn      write clock, synchronous active-low reset
//   start, stop     begin a run (IDLE/DONE only) / end it early (RUN/GAP only)
//   mode            00 incr, 01 LFSR, 10 bursty incr, 11 same as 00
//   num_words       words per run, 0 = continuous
//   full            FIFO backpressure
//   wen, wdata      FIFO write port
//   busy, done      run status
//   sent_cnt        accepted writes in the current run
//   chksum          XOR of accepted wdata in the current run
//                   (present only when FIFO_WR_GEN_CHKSUM_EN is defined)
module fifo_wr_gen #(
    parameter int                D_SIZE    = 8,
    parameter int                CNT_W     = 16,
    parameter int                BURST_LEN = 4,
    parameter int                IDLE_LEN  = 2,
    parameter logic [D_SIZE-1:0] SEED      = D_SIZE'(1),
    parameter logic [D_SIZE-1:0] TAPS      = D_SIZE'(8'hB8)
) (
    input  logic              wclk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              full,
    output logic              wen,
    output logic [D_SIZE-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_cnt
`ifdef FIFO_WR_GEN_CHKSUM_EN
   ,output logic [D_SIZE-1:0] chksum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    localparam logic [1:0] M_INC   = 2'b00;
    localparam logic [1:0] M_LFSR  = 2'b01;
    localparam logic [1:0] M_BURST = 2'b10;

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (IDLE_LEN  > 1) ? $clog2(IDLE_LEN)  : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(IDLE_LEN - 1);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [D_SIZE-1:0] SEED_EFF = (SEED == '0) ? D_SIZE'(1) : SEED;

    state_t            state_q, state_d;
    logic [D_SIZE-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [D_SIZE-1:0] chk_q, chk_d;

    logic              accept;
    logic [CNT_W-1:0]  sent_inc;
    logic [D_SIZE-1:0] next_data;
    logic [1:0]        mode_in;

    assign accept   = (state_q == RUN) && !full;
    assign sent_inc = sent_q + CNT_W'(1);
    // Mode 11 is folded onto incrementing at latch time.
    assign mode_in  = (mode == 2'b11) ? M_INC : mode;

    always_comb begin
        next_data = wdata_q + D_SIZE'(1);
        if (mode_q == M_LFSR)
            next_data = wdata_q[0] ? ((wdata_q >> 1) ^ TAPS) : (wdata_q >> 1);
    end

    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
        sent_d  = sent_q;
        mode_d  = mode_q;
        num_d   = num_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        chk_d   = chk_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode_in;
                    num_d   = num_words;
                    sent_d  = '0;
                    wdata_d = (mode_in == M_LFSR) ? SEED_EFF : '0;
                    burst_d = '0;
                    gap_d   = '0;
                    chk_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    sent_d  = sent_inc;
                    wdata_d = next_data;
                    burst_d = burst_q + BW'(1);
                    chk_d   = chk_q ^ wdata_q;
                end
                if (accept && num_q != '0 && sent_inc == num_q) begin
                    state_d = DONE;
                end else if (stop) begin
                    state_d = DONE;
                end else if (mode_q == M_BURST && accept && burst_q == BURST_LAST) begin
                    state_d = GAP;
                    burst_d = '0;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (stop)
                    state_d = DONE;
                else if (gap_q == GAP_LAST)
                    state_d = RUN;
                else
                    gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!rstn) begin
            state_q <= IDLE;
            wdata_q <= '0;
            sent_q  <= '0;
            mode_q  <= M_INC;
            num_q   <= '0;
            burst_q <= '0;
            gap_q   <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
            sent_q  <= sent_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            burst_q <= burst_d;
            gap_q   <= gap_d;
            chk_q   <= chk_d;
        end
    end

    assign wen      = (state_q == RUN);
    assign busy     = (state_q == RUN) || (state_q == GAP);
    assign done     = (state_q == DONE);
    assign wdata    = wdata_q;
    assign sent_cnt = sent_q;
`ifdef FIFO_WR_GEN_CHKSUM_EN
    assign chksum   = chk_q;
`endif

endmodule

// File: doc/fifo_wr_gen.md
Name: fifo_wr_gen

Overview:
Parametrised write-side traffic generator for the FIFO bench. It drives wen/wdata into a FIFO write port and honours backpressure from full. Supported data patterns are incrementing, LFSR and bursty-incrementing. It runs for a programmed word count or continuously, and reports progress and completion. It runs in the write clock domain, replacing the fixed 5-bit free-running counter source.

Parameters:
D_SIZE, 8, data width in bits (>=2)
CNT_W, 16, width of word-count input and sent counter
BURST_LEN, 4, accepted writes per burst in bursty mode (>=1)
IDLE_LEN, 2, idle cycles between bursts in bursty mode (>=1)
SEED, 1, LFSR start value (D_SIZE bits); a value of 0 is replaced by 1
TAPS, 8'hB8, Galois LFSR feedback mask (D_SIZE bits)

Ports:
wclk  input  1  write clock; all logic on posedge
rstn  input  1  synchronous active-low reset
start  input  1  begin a run; sampled only in IDLE or DONE
stop  input  1  end a run early; sampled only in RUN or GAP
mode  input  2  00 incrementing, 01 LFSR, 10 bursty incrementing, 11 treated as 00
num_words  input  CNT_W  words per run; 0 = continuous until stop
full  input  1  FIFO full, backpressure
wen  output  1  write enable
wdata  output  D_SIZE  write data
busy  output  1  high in RUN or GAP
done  output  1  high in DONE
sent_cnt  output  CNT_W  accepted writes in the current run

Behaviour:
- Synchronous reset: state=IDLE, wen=0, wdata=0, busy=0, done=0, sent_cnt=0, latched mode=00, latched num_words=0.
- Accept = wen & ~full at a posedge. wdata holds stable until the word is accepted; full never drops a word.
- wen is a decode of state, not of full. wen=1 exactly in RUN.
- State IDLE:
  - start -> RUN.
  - Latch mode and num_words.
  - sent_cnt=0.
  - wdata = 0 (modes 00/10) or SEED (mode 01).
- State RUN, on each accept:
  - sent_cnt+1.
  - Next data: increment wraps 2^D_SIZE-1 -> 0; LFSR: lsb ? (d>>1)^TAPS : d>>1.
- State RUN, transitions (priority order):
  1. Accept with num_words!=0 and sent_cnt+1==num_words -> DONE.
  2. stop -> DONE. An accept in the same cycle still counts.
  3. Mode 10 with BURST_LEN accepts in the current burst -> GAP.
- State GAP:
  - wen=0 for exactly IDLE_LEN cycles, then RUN with the burst count cleared.
  - stop -> DONE.
  - Data is not advanced.
- State DONE:
  - wen=0, done=1.
  - sent_cnt and wdata hold.
  - start -> RUN, with the same reinitialisation as IDLE->RUN.
- Continuous mode (num_words=0): sent_cnt wraps 2^CNT_W-1 -> 0; the run continues until stop.
- start while busy and stop while not busy are ignored. mode and num_words changes mid-run are ignored.
- First wen=1 occurs the cycle after start is sampled.
- Reset asserted mid-run aborts it: IDLE next edge, wen=0, regardless of full.
- Full held high indefinitely: remain in RUN with wen=1 and wdata frozen; burst progress frozen.

Optional Feature:
Macro FIFO_WR_GEN_CHKSUM_EN.
- Defined: adds output port chksum (D_SIZE bits), the XOR of every accepted wdata in the current run. Cleared by reset and by each start. Holds in DONE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Mode 00, num_words=5, full=0, start pulse -> wen high 5 cycles, wdata 0,1,2,3,4; then done=1, sent_cnt=5, wen=0.
- Mode 01, SEED=1, num_words=4 -> accepted wdata 8'h01,8'hB8,8'h5C,8'h2E; done=1.
- Mode 10, BURST_LEN=4, IDLE_LEN=2, num_words=10 -> wen pattern 4 high, 2 low, 4 high, 2 low, 2 high; data 0..9 contiguous; done after 10th accept.
- Mode 00, num_words=6, full high for 3 cycles while wdata=2 -> wdata stays 2, sent_cnt stays 2, no gap in sequence afterwards, final sent_cnt=6.
- Mode 00, num_words=0, D_SIZE=8: run 300 accepts then stop -> wdata wraps 255->0, sent_cnt=300 (plus the stop-cycle accept if full=0), done=1. Restart -> wdata=0, sent_cnt=0.
- rstn low mid-run for 1 cycle -> next edge wen=0, busy=0, done=0, sent_cnt=0. With CHKSUM_EN, run of 0..3 gives chksum=8'h00 and run of 0..4 gives 8'h04.
